// File: rtl/serial_wide_adder_ctrl.sv
// Wide adder controller: time-multiplexes an external DATA_WIDTH-bit ripple adder
// one slice per cycle (LSB slice first), with valid/ready on operands and result.
module serial_wide_adder_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_SLICES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*NUM_SLICES-1:0] in_a,
  input  logic [DATA_WIDTH*NUM_SLICES-1:0] in_b,
  input  logic                             in_cin,
  output logic [DATA_WIDTH-1:0]            add_x,
  output logic [DATA_WIDTH-1:0]            add_y,
  output logic                             add_cin,
  input  logic [DATA_WIDTH-1:0]            add_sum,
  input  logic                             add_cout,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_SLICES-1:0] out_sum,
  output logic                             out_cout,
  output logic                             busy
);
  localparam int W     = DATA_WIDTH * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [W-1:0]     r_out_sum;
  logic             r_carry;
  logic             r_out_cout;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_last;
  logic [W-1:0]     w_sum_next;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

  // Operands shift down one slice per RUN cycle while sum slices enter from the top,
  // so after NUM_SLICES cycles slice 0 of the result sits at the bottom of r_sum.
  assign w_sum_next = (W'(add_sum) << (W - DATA_WIDTH)) | (r_sum >> DATA_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)           w_next = S_RUN;
      S_RUN:   if (r_idx == LAST_IDX)  w_next = S_DONE;
      S_DONE:  if (out_ready)          w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  // Adder operands come from registers only, never from input ports.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        busy    = 1'b1;
        add_x   = r_a[DATA_WIDTH-1:0];
        add_y   = r_b[DATA_WIDTH-1:0];
        add_cin = r_carry;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_sum   <= '0;
      r_carry <= in_cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DATA_WIDTH;
      r_b     <= r_b >> DATA_WIDTH;
      r_sum   <= w_sum_next;
      r_carry <= add_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_out_sum  <= w_sum_next;
        r_out_cout <= add_cout;
      end
    end
  end

  // Result registers hold their value outside DONE; out_valid qualifies them.
  assign out_sum  = r_out_sum;
  assign out_cout = r_out_cout;

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Bench for serial_wide_adder_ctrl: three instances (1, 4, 8 slices) each with a
// behavioural slice adder, checked against plain wide arithmetic.
module tb_serial_wide_adder_ctrl;
  localparam int DW   = 4;
  localparam int NK   = 3;
  localparam int MAXW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid  [NK];
  logic            in_ready  [NK];
  logic [MAXW-1:0] in_a      [NK];
  logic [MAXW-1:0] in_b      [NK];
  logic            in_cin    [NK];
  logic [DW-1:0]   add_x     [NK];
  logic [DW-1:0]   add_y     [NK];
  logic            add_cin   [NK];
  logic [DW-1:0]   add_sum   [NK];
  logic            add_cout  [NK];
  logic            out_valid [NK];
  logic            out_ready [NK];
  logic [MAXW-1:0] out_sum   [NK];
  logic            out_cout  [NK];
  logic            busy      [NK];

  int n_vec = 0;
  int n_err = 0;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    localparam int NS = (k == 0) ? 1 : (k == 1) ? 4 : 8;
    logic [DW*NS-1:0] w_sum;

    serial_wide_adder_ctrl #(.DATA_WIDTH(DW), .NUM_SLICES(NS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_a      (in_a[k][DW*NS-1:0]),
      .in_b      (in_b[k][DW*NS-1:0]),
      .in_cin    (in_cin[k]),
      .add_x     (add_x[k]),
      .add_y     (add_y[k]),
      .add_cin   (add_cin[k]),
      .add_sum   (add_sum[k]),
      .add_cout  (add_cout[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_sum   (w_sum),
      .out_cout  (out_cout[k]),
      .busy      (busy[k])
    );

    assign out_sum[k] = MAXW'(w_sum);
    assign {add_cout[k], add_sum[k]} = {1'b0, add_x[k]} + {1'b0, add_y[k]} + {{DW{1'b0}}, add_cin[k]};
  end

  function automatic int ns_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 8;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    for (int k = 0; k < NK; k++) in_valid[k] = 1'b1;
    #12;
    for (int k = 0; k < NK; k++) begin
      n_vec++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
          out_sum[k] !== '0 || out_cout[k] !== 1'b0 || add_x[k] !== '0 ||
          add_y[k] !== '0 || add_cin[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state k=%0d rdy=%b vld=%b busy=%b sum=%h cout=%b x=%h y=%h cin=%b, required 1 0 0 0 0 0 0 0",
                 k, in_ready[k], out_valid[k], busy[k], out_sum[k], out_cout[k], add_x[k], add_y[k], add_cin[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NK; k++) in_valid[k] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NK; k++) begin
      n_vec++;
      if (busy[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_release k=%0d busy=%b rdy=%b, required 0 1", k, busy[k], in_ready[k]);
      end
    end
  endtask

  // One complete transaction: accept, per-slice adder drive, result hold, return to IDLE.
  task automatic test_operation(input int k, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input bit rand_ready);
    int ns, w, cyc;
    bit acc, rel;
    longint unsigned mask, la, lb, lcin, full, m;
    logic [31:0]   exp_sum;
    logic          exp_cout, exp_c;
    logic [DW-1:0] exp_x, exp_y;
    ns       = ns_of(k);
    w        = DW * ns;
    mask     = (64'd1 << w) - 64'd1;
    la       = {32'd0, a} & mask;
    lb       = {32'd0, b} & mask;
    lcin     = {63'd0, cin};
    full     = la + lb + lcin;
    exp_sum  = 32'(full & mask);
    exp_cout = 1'(full >> w);

    in_a[k] = 32'(la); in_b[k] = 32'(lb); in_cin[k] = cin;
    in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    cyc = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk); #1;
      cyc++;
      if (!acc && cyc > 64) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout k=%0d in_ready=%b, required 1 within 64 cycles", k, in_ready[k]);
        in_valid[k] = 1'b0;
        return;
      end
    end

    // Upstream presents a different operand; it must not disturb this one.
    in_valid[k] = 1'($urandom_range(0, 1));
    in_a[k] = $urandom; in_b[k] = $urandom; in_cin[k] = 1'($urandom_range(0, 1));

    for (int s = 0; s < ns; s++) begin
      m     = (64'd1 << (DW * s)) - 64'd1;
      exp_x = DW'(la >> (DW * s));
      exp_y = DW'(lb >> (DW * s));
      exp_c = 1'(((la & m) + (lb & m) + lcin) >> (DW * s));
      @(negedge clk);
      n_vec++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0 || busy[k] !== 1'b1 ||
          add_x[k] !== exp_x || add_y[k] !== exp_y || add_cin[k] !== exp_c) begin
        n_err++;
        $display("FAIL run_slice k=%0d s=%0d x=%h/%h y=%h/%h cin=%b/%b vld=%b/0 rdy=%b/0 busy=%b/1 (actual/required)",
                 k, s, add_x[k], exp_x, add_y[k], exp_y, add_cin[k], exp_c, out_valid[k], in_ready[k], busy[k]);
      end
      @(posedge clk); #1;
    end

    cyc = 0;
    forever begin
      out_ready[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n_vec++;
      if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || busy[k] !== 1'b1 ||
          out_sum[k] !== exp_sum || out_cout[k] !== exp_cout) begin
        n_err++;
        $display("FAIL done_result k=%0d a=%h b=%h cin=%b sum=%h/%h cout=%b/%b vld=%b/1 rdy=%b/0 (actual/required)",
                 k, a, b, cin, out_sum[k], exp_sum, out_cout[k], exp_cout, out_valid[k], in_ready[k]);
      end
      rel = out_ready[k];
      @(posedge clk); #1;
      if (rel) break;
      cyc++;
      if (cyc > 64) begin
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b0;
    n_vec++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || out_sum[k] !== exp_sum || out_cout[k] !== exp_cout) begin
      n_err++;
      $display("FAIL idle_after k=%0d vld=%b/0 rdy=%b/1 sum=%h/%h cout=%b/%b (actual/required)",
               k, out_valid[k], in_ready[k], out_sum[k], exp_sum, out_cout[k], exp_cout);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1, exp2;
    exp1 = 32'h1111 + 32'h2222;
    exp2 = (32'hABCD + 32'h0102 + 32'd1) & 32'hFFFF;
    in_a[1] = 32'h1111; in_b[1] = 32'h2222; in_cin[1] = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_a[1] = 32'hABCD; in_b[1] = 32'h0102; in_cin[1] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_valid[1] !== 1'b1 || out_sum[1] !== exp1 || out_cout[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d vld=%b/1 sum=%h/%h cout=%b/0 rdy=%b/0 (actual/required)",
                 i, out_valid[1], out_sum[1], exp1, out_cout[1], in_ready[1]);
      end
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    n_vec++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release rdy=%b/1 vld=%b/0 (actual/required)", in_ready[1], out_valid[1]);
    end
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    n_vec++;
    if (busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept busy=%b/1 rdy=%b/0 (actual/required)", busy[1], in_ready[1]);
    end
    repeat (4) begin @(posedge clk); #1; end
    n_vec++;
    if (out_valid[1] !== 1'b1 || out_sum[1] !== exp2 || out_cout[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_second vld=%b/1 sum=%h/%h cout=%b/0 (actual/required)",
               out_valid[1], out_sum[1], exp2, out_cout[1]);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    in_a[1] = 32'hFFFF; in_b[1] = 32'h0001; in_cin[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if (add_x[1] !== 4'hF || add_y[1] !== 4'h0 || add_cin[1] !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_slice2 x=%h/f y=%h/0 cin=%b/1 (actual/required)", add_x[1], add_y[1], add_cin[1]);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0 || add_x[1] !== '0 || add_y[1] !== '0 || add_cin[1] !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset vld=%b/0 busy=%b/0 x=%h/0 y=%h/0 cin=%b/0 (actual/required)",
               out_valid[1], busy[1], add_x[1], add_y[1], add_cin[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_operation(1, 32'h0001, 32'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int k, input int n);
    for (int i = 0; i < n; i++)
      test_operation(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; in_cin[k] = 1'b0; out_ready[k] = 1'b0;
    end
    test_reset();
    test_operation(1, 32'h1234, 32'h4321, 1'b0, 1'b0);
    test_operation(1, 32'hFFFF, 32'h0000, 1'b1, 1'b0);
    test_operation(1, 32'h8000, 32'h8000, 1'b0, 1'b0);
    test_operation(0, 32'hF, 32'h1, 1'b1, 1'b0);
    test_operation(2, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    for (int k = 0; k < NK; k++) test_random(k, 1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
